// File: rtl/gpio_out_ctrl.sv
// gpio_out_ctrl: CPU register block driving GPIO demux data/select, with toggle and one-shot pulse mode.
module gpio_out_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  input  logic       we,
  input  logic       re,
  output logic [7:0] rdata,
  output logic [7:0] gpio_out,
  output logic       sel,
  output logic       busy
);
  typedef enum logic {IDLE, PULSE} state_t;
  state_t     state, state_n;
  logic [7:0] data_reg, data_n, cnt, cnt_n, plen, rd_mux;
  logic [1:0] ctrl;
  logic       wr_data, wr_tog, wr_ctrl, wr_plen;
  assign wr_data  = we && addr == 2'd0;
  assign wr_tog   = we && addr == 2'd1;
  assign wr_ctrl  = we && addr == 2'd2;
  assign wr_plen  = we && addr == 2'd3;
  assign gpio_out = data_reg;
  assign sel      = ctrl[0];
  assign busy     = state == PULSE;
  // DATA write beats completion/abort, which beat TOGGLE; cnt parks at 0
  always_comb begin
    state_n = state;
    data_n  = data_reg;
    cnt_n   = cnt;
    if (wr_data) begin
      data_n = wdata;
      if (ctrl[1]) begin
        cnt_n   = plen;
        state_n = PULSE;
      end
    end else if (busy && cnt == 8'd0) begin
      data_n  = 8'd0;
      state_n = IDLE;
    end else if (busy && wr_ctrl && !wdata[1]) begin
      state_n = IDLE;
    end else begin
      cnt_n  = busy ? cnt - 8'd1 : cnt;
      data_n = wr_tog ? data_reg ^ wdata : data_reg;
    end
  end
  always_comb
    rd_mux = addr == 2'd0 ? data_reg :
             addr == 2'd1 ? cnt :
             addr == 2'd2 ? {5'b0, busy, ctrl} : plen;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_reg <= 8'd0;
      cnt      <= 8'd0;
      ctrl     <= 2'd0;
      plen     <= 8'd0;
      rdata    <= 8'd0;
    end else begin
      state    <= state_n;
      data_reg <= data_n;
      cnt      <= cnt_n;
      if (wr_ctrl) ctrl <= wdata[1:0];
      if (wr_plen) plen <= wdata;
      if (re) rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_gpio_out_ctrl.sv
// tb_gpio_out_ctrl: directed plus random stimulus checked against a cycles-remaining reference model.
module tb_gpio_out_ctrl;
  logic       clk = 1'b0, rst, we, re, sel, busy;
  logic [1:0] addr;
  logic [7:0] wdata, rdata, gpio_out;
  int errors = 0, checks = 0;
  logic [7:0] m_data, m_plen, m_cnt, m_rd;
  logic       m_sel, m_pen;
  int         m_left;

  gpio_out_ctrl dut (.clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we), .re(re),
                     .rdata(rdata), .gpio_out(gpio_out), .sel(sel), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // m_left counts output cycles still to be held at the pulse value
  task automatic model(input logic r, w, rd, input logic [1:0] a, input logic [7:0] d);
    if (r) begin
      m_data = 0; m_plen = 0; m_cnt = 0; m_rd = 0; m_sel = 0; m_pen = 0; m_left = 0;
      return;
    end
    if (rd)
      case (a)
        2'd0: m_rd = m_data;
        2'd1: m_rd = m_cnt;
        2'd2: m_rd = {5'b0, m_left > 0, m_pen, m_sel};
        default: m_rd = m_plen;
      endcase
    if (w && a == 0) begin
      m_data = d;
      if (m_pen) begin
        m_left = m_plen + 1;
        m_cnt = m_plen;
      end
    end else if (m_left == 1) begin
      m_data = 0;
      m_left = 0;
    end else if (m_left > 1 && w && a == 2 && !d[1]) begin
      m_left = 0;
    end else begin
      if (m_left > 1) begin
        m_left--;
        m_cnt = 8'(m_left - 1);
      end
      if (w && a == 1) m_data = m_data ^ d;
    end
    if (w && a == 2) begin
      m_sel = d[0];
      m_pen = d[1];
    end
    if (w && a == 3) m_plen = d;
  endtask

  task automatic cyc(input logic r, w, rd, input logic [1:0] a, input logic [7:0] d);
    rst = r; we = w; re = rd; addr = a; wdata = d;
    model(r, w, rd, a, d);
    @(posedge clk);
    #1;
    check("gpio", gpio_out, m_data);
    check("sel", sel, m_sel);
    check("busy", busy, m_left > 0);
    check("rdata", rdata, m_rd);
    rst = 0; we = 0; re = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic width(input logic [7:0] pl);
    int n;
    cyc(0, 1, 0, 2, 8'h02);
    cyc(0, 1, 0, 3, pl);
    cyc(0, 1, 0, 0, 8'h5A);
    n = busy ? 1 : 0;
    for (int i = 0; i < 300 && busy; i++) begin
      idle(1);
      if (busy) n++;
    end
    check("width", n, pl + 1);
    check("width_clr", gpio_out, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_gpio", gpio_out, 0);
    check("rst_busy", busy, 0);
    // direct write, no pulse
    cyc(0, 1, 0, 0, 8'hA5);
    idle(3);
    cyc(0, 0, 1, 0, 0);
    check("direct", rdata, 8'hA5);
    check("direct_busy", busy, 0);
    // pulse plen=3 with counter readback
    cyc(0, 1, 0, 2, 8'h02);
    cyc(0, 1, 0, 3, 8'd3);
    cyc(0, 1, 0, 0, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      check("pulse_val", gpio_out, 8'h3C);
      cyc(0, 0, 1, 1, 0);
      check("cnt_rd", rdata, 3 - i);
    end
    check("pulse_end", gpio_out, 0);
    // retrigger
    cyc(0, 1, 0, 3, 8'd5);
    cyc(0, 1, 0, 0, 8'hFF);
    idle(1);
    cyc(0, 1, 0, 0, 8'h0F);
    idle(5);
    check("retrig_hold", gpio_out, 8'h0F);
    idle(1);
    check("retrig_end", gpio_out, 0);
    // boundary widths
    width(8'd0);
    width(8'd255);
    // toggle
    cyc(0, 1, 0, 2, 8'h00);
    cyc(0, 1, 0, 0, 8'hF0);
    cyc(0, 1, 0, 1, 8'h3C);
    cyc(0, 0, 1, 0, 0);
    check("toggle", rdata, 8'hCC);
    // toggle on completion cycle is dropped
    cyc(0, 1, 0, 2, 8'h02);
    cyc(0, 1, 0, 3, 8'd1);
    cyc(0, 1, 0, 0, 8'h55);
    idle(1);
    cyc(0, 1, 0, 1, 8'hFF);
    check("tog_drop", gpio_out, 0);
    // abort
    cyc(0, 1, 0, 3, 8'd10);
    cyc(0, 1, 0, 0, 8'h81);
    idle(2);
    cyc(0, 1, 0, 2, 8'h01);
    check("abort_gpio", gpio_out, 8'h81);
    check("abort_busy", busy, 0);
    check("abort_sel", sel, 1);
    // reset mid-pulse
    cyc(0, 1, 0, 2, 8'h03);
    cyc(0, 1, 0, 3, 8'd20);
    cyc(0, 1, 0, 0, 8'h77);
    idle(2);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("mid_rst_gpio", gpio_out, 0);
    check("mid_rst_rdata", rdata, 0);
    // simultaneous write/read of PLEN
    cyc(0, 1, 0, 3, 8'd7);
    cyc(0, 1, 1, 3, 8'd9);
    check("wr_rd_same", rdata, 7);
    // random
    for (int i = 0; i < 4000; i++) begin
      logic [1:0] a;
      logic [7:0] d;
      a = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if (a == 3 && $urandom_range(0, 3) != 0) d = 8'($urandom_range(0, 6));
      if (a == 2 && $urandom_range(0, 2) != 0) d[1] = 1'b1;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0, a, d);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
